// File: rtl/ps2_key_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ps2_key_pkg                                              |
// | Description : Shared constants and types for the PS/2 key controller:  |
// |               Set-2 prefix bytes, parser state encoding, default game  |
// |               scancodes and the 10-bit key event layout.               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package ps2_key_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    // Parser state encoding (2 bits)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_GOT_E0  = 2'd1;
    localparam state_t ST_GOT_F0  = 2'd2;
    localparam state_t ST_GOT_E0F0 = 2'd3;

    // Default game scancodes
    localparam logic [7:0] DEF_SC_P1_UP = 8'h1D;
    localparam logic [7:0] DEF_SC_P1_DN = 8'h1B;
    localparam logic [7:0] DEF_SC_P2_UP = 8'h75;
    localparam logic [7:0] DEF_SC_P2_DN = 8'h72;
    localparam logic [7:0] DEF_SC_START = 8'h29;
    localparam logic [7:0] DEF_SC_PAUSE = 8'h4D;

    // Key event: {ext, brk, code}
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

endpackage
`default_nettype wire

// File: rtl/ps2_key_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ps2_key_fifo                                             |
// | Description : Small FIFO of key events. A push into a full FIFO is     |
// |               dropped and latches the sticky overflow flag, unless a   |
// |               pop happens in the same cycle.                           |
// | Ports       : clk, rst_n (sync, active-low), push/din, pop/dout,       |
// |               empty, overflow                                          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ps2_key_fifo
    import ps2_key_pkg::*;
#(
    parameter int DEPTH = 4   // must be a power of two
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  ev_t  din,
    input  logic pop,
    output ev_t  dout,
    output logic empty,
    output logic overflow
);

    localparam int c_aw = $clog2(DEPTH);

    ev_t             r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == (c_aw+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (push && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign dout     = r_mem[r_rd_ptr];
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ps2_key_ctrl                                             |
// | Description : Parses the PS/2 Set-2 byte stream (plain, E0-extended,   |
// |               F0-break) into key events, tracks the four paddle key    |
// |               levels and generates start / pause-toggle commands.      |
// |               A watchdog aborts stalled multi-byte sequences.          |
// | Ports       : clk, rst_n (sync, active-low), rx_data/rx_valid in;      |
// |               p1_up/p1_dn/p2_up/p2_dn levels, start_pulse,             |
// |               pause_state, ev_valid/ev_code/ev_ext/ev_brk,             |
// |               err_timeout out.                                         |
// | Option      : PS2_KEY_FIFO_EN adds ev_ready/ev_overflow and a 4-entry  |
// |               event FIFO with backpressure.                            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ps2_key_ctrl
    import ps2_key_pkg::*;
#(
    parameter int         CLK_HZ     = 50_000_000,
    parameter int         TIMEOUT_MS = 2,
    parameter logic [7:0] SC_P1_UP   = DEF_SC_P1_UP,
    parameter logic [7:0] SC_P1_DN   = DEF_SC_P1_DN,
    parameter logic [7:0] SC_P2_UP   = DEF_SC_P2_UP,
    parameter logic [7:0] SC_P2_DN   = DEF_SC_P2_DN,
    parameter logic [7:0] SC_START   = DEF_SC_START,
    parameter logic [7:0] SC_PAUSE   = DEF_SC_PAUSE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       p1_up,
    output logic       p1_dn,
    output logic       p2_up,
    output logic       p2_dn,
    output logic       start_pulse,
    output logic       pause_state,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       err_timeout
`ifdef PS2_KEY_FIFO_EN
    ,
    input  logic       ev_ready,
    output logic       ev_overflow
`endif
);

    localparam int c_timeout_cyc = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int c_wd_w        = $clog2(c_timeout_cyc);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(c_timeout_cyc - 1);

    state_t            r_state;
    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_p1_up;
    logic              r_p1_dn;
    logic              r_p2_up;
    logic              r_p2_dn;
    logic              r_start_pulse;
    logic              r_start_held;
    logic              r_pause_state;
    logic              r_pause_held;
    logic              r_err_timeout;

    state_t w_state_nxt;
    logic   w_emit;
    ev_t    w_ev;
    logic   w_timeout;

    // Byte decode: prefixes only move the state, any other byte emits.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_ev.ext    = 1'b0;
        w_ev.brk    = 1'b0;
        w_ev.code   = rx_data;
        if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == PFX_EXT) begin
                        w_state_nxt = ST_GOT_E0;
                    end else if (rx_data == PFX_BRK) begin
                        w_state_nxt = ST_GOT_F0;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                ST_GOT_E0: begin
                    if (rx_data == PFX_EXT) begin
                        w_state_nxt = ST_GOT_E0;
                    end else if (rx_data == PFX_BRK) begin
                        w_state_nxt = ST_GOT_E0F0;
                    end else begin
                        w_emit      = 1'b1;
                        w_ev.ext    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    w_emit      = 1'b1;
                    w_ev.brk    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_emit      = 1'b1;
                    w_ev.ext    = 1'b1;
                    w_ev.brk    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
        // An arriving byte always beats the watchdog in the same cycle.
        w_timeout = !rx_valid && (r_state != ST_IDLE) && (r_wd_cnt == c_wd_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wd_cnt      <= '0;
            r_p1_up       <= 1'b0;
            r_p1_dn       <= 1'b0;
            r_p2_up       <= 1'b0;
            r_p2_dn       <= 1'b0;
            r_start_pulse <= 1'b0;
            r_start_held  <= 1'b0;
            r_pause_state <= 1'b0;
            r_pause_held  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_start_pulse <= 1'b0;
            r_err_timeout <= 1'b0;
            if (w_timeout) begin
                r_state       <= ST_IDLE;
                r_wd_cnt      <= '0;
                r_err_timeout <= 1'b1;
            end else begin
                r_state  <= w_state_nxt;
                r_wd_cnt <= (rx_valid || r_state == ST_IDLE) ? '0 : r_wd_cnt + 1'b1;
            end

            if (w_emit) begin
                if (w_ev.code == SC_P1_UP && !w_ev.ext) r_p1_up <= !w_ev.brk;
                if (w_ev.code == SC_P1_DN && !w_ev.ext) r_p1_dn <= !w_ev.brk;
                if (w_ev.code == SC_P2_UP &&  w_ev.ext) r_p2_up <= !w_ev.brk;
                if (w_ev.code == SC_P2_DN &&  w_ev.ext) r_p2_dn <= !w_ev.brk;

                // Held flags suppress typematic repeats of the command keys.
                if (w_ev.code == SC_START && !w_ev.ext) begin
                    if (w_ev.brk) begin
                        r_start_held <= 1'b0;
                    end else if (!r_start_held) begin
                        r_start_held  <= 1'b1;
                        r_start_pulse <= 1'b1;
                    end
                end
                if (w_ev.code == SC_PAUSE && !w_ev.ext) begin
                    if (w_ev.brk) begin
                        r_pause_held <= 1'b0;
                    end else if (!r_pause_held) begin
                        r_pause_held  <= 1'b1;
                        r_pause_state <= !r_pause_state;
                    end
                end
            end
        end
    end

    assign p1_up       = r_p1_up;
    assign p1_dn       = r_p1_dn;
    assign p2_up       = r_p2_up;
    assign p2_dn       = r_p2_dn;
    assign start_pulse = r_start_pulse;
    assign pause_state = r_pause_state;
    assign err_timeout = r_err_timeout;

`ifdef PS2_KEY_FIFO_EN
    ev_t  w_head;
    logic w_empty;

    ps2_key_fifo #(
        .DEPTH (4)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_emit),
        .din      (w_ev),
        .pop      (ev_ready),
        .dout     (w_head),
        .empty    (w_empty),
        .overflow (ev_overflow)
    );

    assign ev_valid = !w_empty;
    assign ev_code  = w_head.code;
    assign ev_ext   = w_head.ext;
    assign ev_brk   = w_head.brk;
`else
    ev_t  r_ev;
    logic r_ev_valid;

    // Event fields hold until the next event; only the strobe drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ev       <= '0;
            r_ev_valid <= 1'b0;
        end else begin
            r_ev_valid <= w_emit;
            if (w_emit) begin
                r_ev <= w_ev;
            end
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_code  = r_ev.code;
    assign ev_ext   = r_ev.ext;
    assign ev_brk   = r_ev.brk;
`endif

endmodule
`default_nettype wire

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sits downstream of the PS/2 receive interface and consumes its byte stream (rx_data/rx_valid).
- Parses Set-2 scancode sequences (plain, E0-extended, F0-break) into make/break key events.
- Keeps held-state for the four paddle keys and produces one-shot game commands (start, pause toggle) for the Pong game logic.
- A parser watchdog resynchronises the FSM when a multi-byte sequence stalls.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
TIMEOUT_MS, 2, maximum gap between bytes of one sequence before the parser aborts
SC_P1_UP, 8'h1D, player-1 up key (W), non-extended
SC_P1_DN, 8'h1B, player-1 down key (S), non-extended
SC_P2_UP, 8'h75, player-2 up key (Up arrow), E0-extended
SC_P2_DN, 8'h72, player-2 down key (Down arrow), E0-extended
SC_START, 8'h29, start key (Space), non-extended
SC_PAUSE, 8'h4D, pause key (P), non-extended

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
rx_data  in  8  received byte from the PS/2 interface
rx_valid  in  1  one-cycle strobe qualifying rx_data
p1_up, p1_dn, p2_up, p2_dn  out  1 each  key-held levels
start_pulse  out  1  one-cycle pulse on a fresh Space make
pause_state  out  1  toggles on each fresh P make
ev_valid  out  1  key event strobe
ev_code  out  8  event scancode
ev_ext  out  1  event was E0-prefixed
ev_brk  out  1  event is a break (release)
err_timeout  out  1  one-cycle pulse when the watchdog aborts a sequence

Behaviour:
- Reset: all outputs 0, FSM in IDLE, watchdog counter 0, start/pause held flags 0.
- FSM states:
  - IDLE: on rx_valid, E0 -> GOT_E0; F0 -> GOT_F0; any other byte emits a make event with ext=0 and stays in IDLE.
  - GOT_E0: on rx_valid, F0 -> GOT_E0F0; any other byte emits a make event with ext=1 and returns to IDLE.
  - GOT_F0: on rx_valid, emits a break event with ext=0 and returns to IDLE.
  - GOT_E0F0: on rx_valid, emits a break event with ext=1 and returns to IDLE.
- Prefix bytes never generate events. A repeated E0 in GOT_E0 stays in GOT_E0. F0 in GOT_F0 or GOT_E0F0 is treated as a code byte.
- Latency: ev_* and key levels update on the clk edge after the edge that samples rx_valid (1 cycle). ev_code/ev_ext/ev_brk hold their value until the next event.
- Key mapping:
  - Code and ext must both match: P1 keys require ext=0, P2 keys require ext=1.
  - Make sets the level; break clears it.
  - Up and down held together drive both levels high; the consumer resolves the conflict.
- Start and pause keys:
  - start_pulse and pause_state act only on a make while the key's held flag is 0; the make sets the held flag and the matching break clears it. Typematic repeats are therefore ignored.
  - start_pulse is high for exactly 1 cycle. pause_state inverts once.
- Watchdog:
  - TIMEOUT_CYC = CLK_HZ/1000*TIMEOUT_MS.
  - In any state other than IDLE, the counter increments each cycle and clears on rx_valid.
  - At TIMEOUT_CYC-1 the FSM returns to IDLE, err_timeout pulses 1 cycle, and no event is emitted.
  - In IDLE the counter is held at 0.
- rx_valid arriving in the same cycle as the timeout: the byte wins; it is processed normally and no error is raised.
- Reset mid-sequence: the partial prefix is discarded and key levels clear.
- Unknown codes, including AA and FA, still emit an ev_* event but affect no level.

Optional Feature:
PS2_KEY_FIFO_EN
- Defined:
  - Adds input ev_ready and output ev_overflow.
  - Events pass through a 4-entry FIFO of {ext, brk, code}.
  - ev_valid means the FIFO is non-empty; an entry pops when ev_valid && ev_ready.
  - A push while the FIFO is full drops the new event and sets the sticky ev_overflow, which only reset clears.
  - A simultaneous push and pop when full is accepted.
  - Key levels and commands are unaffected by backpressure.
- Undefined: events are a 1-cycle strobe with no backpressure; the ev_ready and ev_overflow ports are absent.

Decomposition:
- Package ps2_key_pkg holds:
  - the prefix constants PFX_EXT=8'hE0 and PFX_BRK=8'hF0;
  - the FSM state encoding (2-bit: IDLE, GOT_E0, GOT_F0, GOT_E0F0);
  - the default scancode constants;
  - the event struct layout (10 bits).
- One sub-module, ps2_key_fifo, is instantiated only under PS2_KEY_FIFO_EN.

Test Plan:
- Bytes 1D, F0 1D -> p1_up rises 1 cycle after the first rx_valid; events {1D,ext0,brk0} then {1D,ext0,brk1}; p1_up returns to 0.
- Bytes E0 75, E0 F0 75 -> p2_up=1 then 0; two events with ext=1; prefixes produce no ev_valid.
- Bytes 29, 29, 29, F0 29, 29 -> exactly two start_pulse cycles (first make, and the make after release).
- Byte E0, then no byte for TIMEOUT_CYC cycles (TIMEOUT_MS=1 at CLK_HZ=1e6, i.e. 1000 cycles), then 1D -> err_timeout pulse at cycle 999; 1D decodes as non-extended and p1_up=1.
- rst_n low between E0 and 75 -> after release, 75 decodes as non-extended and p2_up stays 0.
- With PS2_KEY_FIFO_EN and ev_ready=0, send 6 make codes -> 4 entries stored, ev_overflow=1; raising ev_ready drains the first 4 codes in order.
